// File: rtl/oam_dma_arbiter.sv
// Sprite OAM DMA arbiter: shares the external bus between the 6502 core and the
// OAM DMA engine, stalling the core through RDY while 256 bytes are copied.
module oam_dma_arbiter #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_write,
    output logic        cpu_rdy,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_write,
    input  logic [7:0]  bus_rdata,
    output logic        dma_active,
    output logic        put_cycle
);

    // state | meaning
    // IDLE  | core owns the bus, waiting for a write to the DMA register
    // HALT  | RDY low; core writes still complete, waiting for its first read
    // ALIGN | one dummy read so that the first transfer read lands on a get cycle
    // READ  | get cycle: fetch source byte {page, index} into the latch
    // WRITE | put cycle: store latch to the OAM data port, advance index
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] HALT  = 3'd1;
    localparam logic [2:0] ALIGN = 3'd2;
    localparam logic [2:0] READ  = 3'd3;
    localparam logic [2:0] WRITE = 3'd4;

    logic [2:0] state;
    logic [2:0] state_next;
    logic       parity;
    logic [7:0] page;
    logic [7:0] index;
    logic [7:0] latch;
    logic       trigger;

    assign trigger = cpu_write && (cpu_addr == DMA_REG_ADDR);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (trigger) state_next = HALT;
            end
            HALT: begin
                // The halt read must be followed by a get cycle for READ.
                if (!cpu_write) state_next = parity ? READ : ALIGN;
            end
            ALIGN: state_next = READ;
            READ:  state_next = WRITE;
            WRITE: state_next = (index == 8'hFF) ? IDLE : READ;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            parity <= 1'b0;
            page   <= 8'h00;
            index  <= 8'h00;
            latch  <= 8'h00;
        end else begin
            state  <= state_next;
            parity <= ~parity;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        page  <= cpu_wdata;
                        index <= 8'h00;
                    end
                end
                READ:  latch <= bus_rdata;
                WRITE: index <= index + 8'h01;
                default: ;
            endcase
        end
    end

    assign cpu_rdy    = (state == IDLE);
    assign dma_active = (state != IDLE);
    assign put_cycle  = parity;

    always_comb begin
        bus_addr  = cpu_addr;
        bus_wdata = cpu_wdata;
        bus_write = cpu_write;
        case (state)
            ALIGN: bus_write = 1'b0;
            READ: begin
                bus_addr  = {page, index};
                bus_write = 1'b0;
            end
            WRITE: begin
                bus_addr  = OAM_DATA_ADDR;
                bus_wdata = latch;
                bus_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter: IDLE pass-through vectors plus full DMA
// sequences for both alignments, pending writes, re-trigger, data and reset abort.
module tb_oam_dma_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_write;
    logic        cpu_rdy;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_write;
    logic [7:0]  bus_rdata;
    logic        dma_active;
    logic        put_cycle;

    always #5 clk = ~clk;

    oam_dma_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_write  (cpu_write),
        .cpu_rdy    (cpu_rdy),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_write  (bus_write),
        .bus_rdata  (bus_rdata),
        .dma_active (dma_active),
        .put_cycle  (put_cycle)
    );

    // Memory: every byte is its low address bits xor A5.
    assign bus_rdata = bus_addr[7:0] ^ 8'hA5;

    // Expected cycle parity: zero in reset, toggles on every edge afterwards.
    logic exp_par;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_par <= 1'b0;
        else        exp_par <= ~exp_par;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [15:0] a, input logic [7:0] d, input logic w);
        @(posedge clk);
        #1;
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_write = w;
        @(negedge clk);
    endtask

    task automatic chk_pass(input string tag, input logic [15:0] a, input logic [7:0] d, input logic w);
        chk({tag, "_addr"},  bus_addr,  a);
        chk({tag, "_wdata"}, bus_wdata, d);
        chk({tag, "_write"}, bus_write, w);
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        write;
        logic [15:0] e_addr;
        logic [7:0]  e_wdata;
        logic        e_write;
        logic        e_rdy;
        logic        e_active;
    } vec_t;

    vec_t vecs[8];

    task automatic run_dma(input string tag, input logic [7:0] page, input logic want_align,
                           input int n_pend, input logic retrig, input int abort_after);
        logic        halt_par;
        logic        trig_par;
        logic [15:0] pa;
        logic [7:0]  pd;
        int          stall;
        int          oam_writes;
        halt_par = !want_align;
        trig_par = halt_par ^ ~n_pend[0];
        while ((!exp_par) != trig_par) cyc(16'h8000, 8'h00, 1'b0);

        cyc(16'h4014, page, 1'b1);
        chk_pass({tag, "_trig"}, 16'h4014, page, 1'b1);
        chk({tag, "_trig_rdy"}, cpu_rdy, 1'b1);
        chk({tag, "_trig_active"}, dma_active, 1'b0);

        for (int k = 0; k < n_pend; k++) begin
            if (retrig && k == 0) begin
                pa = 16'h4014;
                pd = 8'h07;
            end else begin
                pa = 16'h01FF - 16'(k);
                pd = 8'h30 + 8'(k);
            end
            cyc(pa, pd, 1'b1);
            chk_pass({tag, "_pend"}, pa, pd, 1'b1);
            chk({tag, "_pend_rdy"}, cpu_rdy, 1'b0);
            chk({tag, "_pend_active"}, dma_active, 1'b1);
        end

        cyc(16'h8000, 8'h00, 1'b0);
        chk_pass({tag, "_halt"}, 16'h8000, 8'h00, 1'b0);
        chk({tag, "_halt_rdy"}, cpu_rdy, 1'b0);
        chk({tag, "_halt_par"}, put_cycle, halt_par);
        stall = (cpu_rdy === 1'b0) ? 1 : 0;

        if (want_align) begin
            cyc(16'h8000, 8'h00, 1'b0);
            chk({tag, "_align_addr"}, bus_addr, 16'h8000);
            chk({tag, "_align_write"}, bus_write, 1'b0);
            chk({tag, "_align_put"}, put_cycle, 1'b1);
            stall += (cpu_rdy === 1'b0) ? 1 : 0;
        end

        for (int i = 0; i < 256; i++) begin
            if (i == abort_after) begin
                @(posedge clk);
                #1;
                rst_n     = 1'b0;
                cpu_addr  = 16'h1234;
                cpu_wdata = 8'h5A;
                cpu_write = 1'b1;
                #1;
                chk({tag, "_rst_rdy"}, cpu_rdy, 1'b1);
                chk({tag, "_rst_active"}, dma_active, 1'b0);
                chk_pass({tag, "_rst"}, 16'h1234, 8'h5A, 1'b1);
                @(negedge clk);
                @(negedge clk);
                chk_pass({tag, "_rst_hold"}, 16'h1234, 8'h5A, 1'b1);
                chk({tag, "_rst_put"}, put_cycle, 1'b0);
                rst_n = 1'b1;
                oam_writes = 0;
                for (int c = 0; c < 20; c++) begin
                    cyc(16'h8000, 8'h00, 1'b0);
                    if (bus_write === 1'b1 && bus_addr === 16'h2004) oam_writes++;
                end
                chk({tag, "_post_oam_writes"}, oam_writes, 0);
                chk({tag, "_post_rdy"}, cpu_rdy, 1'b1);
                chk({tag, "_post_active"}, dma_active, 1'b0);
                return;
            end
            cyc(16'h8000, 8'h00, 1'b0);
            chk({tag, "_rd_addr"}, bus_addr, {page, 8'(i)});
            chk({tag, "_rd_write"}, bus_write, 1'b0);
            chk({tag, "_rd_put"}, put_cycle, 1'b0);
            chk({tag, "_rd_active"}, dma_active, 1'b1);
            stall += (cpu_rdy === 1'b0) ? 1 : 0;
            cyc(16'h8000, 8'h00, 1'b0);
            chk({tag, "_wr_addr"}, bus_addr, 16'h2004);
            chk({tag, "_wr_data"}, bus_wdata, 8'(i) ^ 8'hA5);
            chk({tag, "_wr_write"}, bus_write, 1'b1);
            chk({tag, "_wr_put"}, put_cycle, 1'b1);
            stall += (cpu_rdy === 1'b0) ? 1 : 0;
        end

        cyc(16'h8000, 8'h00, 1'b0);
        chk({tag, "_rel_rdy"}, cpu_rdy, 1'b1);
        chk({tag, "_rel_active"}, dma_active, 1'b0);
        chk_pass({tag, "_rel"}, 16'h8000, 8'h00, 1'b0);
        chk({tag, "_stall"}, stall, want_align ? 514 : 513);
    endtask

    initial begin
        vecs[0] = '{16'h8000, 8'h00, 1'b0, 16'h8000, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{16'h0000, 8'h55, 1'b1, 16'h0000, 8'h55, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{16'h4014, 8'h02, 1'b0, 16'h4014, 8'h02, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h4015, 8'h0F, 1'b1, 16'h4015, 8'h0F, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{16'h2004, 8'hAA, 1'b1, 16'h2004, 8'hAA, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{16'hFFFC, 8'hC3, 1'b0, 16'hFFFC, 8'hC3, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{16'h4013, 8'h01, 1'b1, 16'h4013, 8'h01, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{16'h0214, 8'h99, 1'b1, 16'h0214, 8'h99, 1'b1, 1'b1, 1'b0};

        rst_n     = 1'b0;
        cpu_addr  = 16'h1234;
        cpu_wdata = 8'h5A;
        cpu_write = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_rdy", cpu_rdy, 1'b1);
        chk("reset_active", dma_active, 1'b0);
        chk("reset_put", put_cycle, 1'b0);
        chk_pass("reset", 16'h1234, 8'h5A, 1'b1);
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            cyc(vecs[v].addr, vecs[v].wdata, vecs[v].write);
            chk_pass($sformatf("vec%0d", v), vecs[v].e_addr, vecs[v].e_wdata, vecs[v].e_write);
            chk($sformatf("vec%0d_rdy", v), cpu_rdy, vecs[v].e_rdy);
            chk($sformatf("vec%0d_active", v), dma_active, vecs[v].e_active);
            chk($sformatf("vec%0d_put", v), put_cycle, exp_par);
        end

        run_dma("even",   8'h02, 1'b0, 0, 1'b0, -1);
        run_dma("odd",    8'h02, 1'b1, 0, 1'b0, -1);
        run_dma("pend",   8'h02, 1'b0, 2, 1'b0, -1);
        run_dma("retrig", 8'h02, 1'b1, 1, 1'b1, -1);
        run_dma("data",   8'h03, 1'b0, 0, 1'b0, -1);
        run_dma("abort",  8'h03, 1'b1, 0, 1'b0, 100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
